exe_stage_pipe: RTL and testbench
=================================

Name: exe_stage_pipe

Overview:
- Parametrised, pipelined successor to the combinational execute stage.
- Registers its results into an EX/MEM output latch and uses valid/ready handshakes on both sides.
- Adds shifts and an iterative multi-cycle multiply, a configurable compare mode and a pipeline flush.
- Sits between the ID/EX latch and the MEM stage; branch resolution (sel, target) is produced here.

Parameters:
- XLEN, 32: datapath width of A, B, Imm, NPC, IR and the result.
- SIGNED_CMP, 0: 0 means func 5 is an unsigned a>b; 1 means a signed a>b.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill the in-flight op and the output latch.
- in_valid  in  1  ID/EX presents an op.
- in_ready  out  1  stage can accept this cycle.
- A  in  XLEN  rs1 operand.
- B  in  XLEN  rs2 operand / store data.
- Imm  in  XLEN  sign-extended immediate.
- NPC_id  in  XLEN  next PC of the op.
- IR_id  in  32  instruction; opcode = IR_id[31:26].
- out_valid  out  1  output latch holds a result.
- out_ready  in  1  MEM stage consumes the result.
- NPC_ex  out  XLEN  next PC after resolution.
- IR_ex  out  32  registered IR.
- ALU_res  out  XLEN  registered result.
- B_ex  out  XLEN  registered B (store data).
- sel  out  1  branch taken.
- busy  out  1  multiply in progress.

Behaviour:
- Operand select:
  - a = NPC_id when opcode[5:2]==4'b1101, else A.
  - b = Imm when opcode[4]==1, else B.
- opcode[5]==0 selects ALU ops by func = opcode[3:0]:
  - 0 add; 1 sub; 2 xor; 3 and; 4 or.
  - 5 a>b returns 1/0, compare mode per SIGNED_CMP.
  - 6 sll by b[$clog2(XLEN)-1:0]; 7 srl by b[$clog2(XLEN)-1:0].
  - 8 mul, low XLEN bits, multi-cycle.
  - 9-15 produce result 0.
- opcode[5]==1 (ld/st/branch): result = a+b.
- Arithmetic wraps modulo 2^XLEN. No flags are produced.
- Branch (opcode[5:1]==5'b11010):
  - sel = opcode[0] ^ (A==0).
  - NPC_ex = result when sel=1, else NPC_id.
  - For non-branches, sel=0 and NPC_ex=NPC_id.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
  - Accept occurs when in_valid && in_ready at the clock edge.
  - The output latch changes only on accept, on mul completion, or when drained (out_valid && out_ready with nothing new loaded, which clears out_valid).
- States:
  - IDLE: accepting a non-mul op loads the latch at the same edge, so latency is 1 cycle and out_valid is high in the next cycle. Accepting a mul captures the operands and moves to MUL.
  - MUL: shift-add, one multiplier bit per cycle, with a counter from 0 to XLEN-1. busy=1 and in_ready=0. At the edge where counter==XLEN-1, the result, IR, NPC and B are loaded, out_valid becomes 1 and the state returns to IDLE. A mul accepted at edge k shows out_valid after edge k+XLEN.
  - Because a mul can only be accepted when the latch is empty or draining, the latch is guaranteed empty at mul completion.
- Back-pressure: while out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Simultaneous drain and accept: the latch is overwritten with the new op and out_valid stays 1.
- Flush: takes precedence over everything except rst. At that edge out_valid goes to 0, state goes to IDLE, the counter is cleared and no accept occurs.
- Reset:
  - out_valid, sel, busy go to 0.
  - NPC_ex, IR_ex, ALU_res, B_ex go to 0.
  - State goes to IDLE and the counter to 0.
  - Reset during MUL abandons the multiply.

Test Plan:
- ADD RR: IR opcode 000000, A=5, B=7, out_ready=1 -> next cycle out_valid=1, ALU_res=12, sel=0, NPC_ex=NPC_id.
- Immediate and compare: opcode 010101, A=3, Imm=32'hFFFFFFFF -> ALU_res=0 with SIGNED_CMP=0, and 1 with SIGNED_CMP=1. opcode 010110, A=1, Imm=31 -> 32'h80000000.
- Multiply: opcode 001000, A=32'h0001_0003, B=32'h0000_0005 -> busy=1 and in_ready=0 for 32 cycles, out_valid after edge k+32, ALU_res=32'h0005_000F. A 2nd op held on in_valid is accepted only afterwards.
- Branch: opcode 110100, A=0, NPC_id=100, Imm=20 -> sel=1, NPC_ex=120. opcode 110101, A=0 -> sel=0, NPC_ex=100.
- Back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0. Raising out_ready with a new op on the same edge -> the latch is replaced and out_valid stays 1.
- Flush/reset: flush asserted in the 10th MUL cycle -> next cycle busy=0 and out_valid=0, then a new ADD completes normally. rst mid-MUL -> all outputs 0 after the edge.

Source files
------------

// File: rtl/exe_stage_pipe.sv
// Pipelined execute stage: operand select, ALU/shift/compare, branch resolution,
// a bit-serial shift-add multiplier and a valid/ready EX/MEM output latch.
module exe_stage_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter bit          SIGNED_CMP = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] Imm,
  input  logic [XLEN-1:0] NPC_id,
  input  logic [31:0]     IR_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] NPC_ex,
  output logic [31:0]     IR_ex,
  output logic [XLEN-1:0] ALU_res,
  output logic [XLEN-1:0] B_ex,
  output logic            sel,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state_q;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] mcand_q, mplier_q, acc_q, acc_d;
  logic [XLEN-1:0] npcHold_q, bHold_q;
  logic [31:0]     irHold_q;

  logic            outValid_q, sel_q;
  logic [XLEN-1:0] npcEx_q, aluRes_q, bEx_q;
  logic [31:0]     irEx_q;

  logic [5:0]      opcode;
  logic [3:0]      func;
  logic [XLEN-1:0] opA, opB, aluResult;
  logic            gt, isMul, isBranch, takeBranch, accept;

  always_comb begin
    opcode     = IR_id[31:26];
    func       = opcode[3:0];
    opA        = (opcode[5:2] == 4'b1101) ? NPC_id : A;
    opB        = opcode[4] ? Imm : B;
    gt         = SIGNED_CMP ? ($signed(opA) > $signed(opB)) : (opA > opB);
    isMul      = !opcode[5] && (func == 4'd8);
    isBranch   = (opcode[5:1] == 5'b11010);
    // Branch condition looks at the raw rs1 value, not the NPC-substituted operand.
    takeBranch = isBranch && (opcode[0] ^ (A == '0));
    aluResult  = '0;
    if (opcode[5]) begin
      aluResult = opA + opB;
    end else begin
      case (func)
        4'd0:    aluResult = opA + opB;
        4'd1:    aluResult = opA - opB;
        4'd2:    aluResult = opA ^ opB;
        4'd3:    aluResult = opA & opB;
        4'd4:    aluResult = opA | opB;
        4'd5:    aluResult = {{(XLEN-1){1'b0}}, gt};
        4'd6:    aluResult = opA << opB[SHW-1:0];
        4'd7:    aluResult = opA >> opB[SHW-1:0];
        default: aluResult = '0;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE) && (!outValid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      npcHold_q  <= '0;
      bHold_q    <= '0;
      irHold_q   <= '0;
      outValid_q <= 1'b0;
      sel_q      <= 1'b0;
      npcEx_q    <= '0;
      aluRes_q   <= '0;
      bEx_q      <= '0;
      irEx_q     <= '0;
    end else if (flush) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && isMul) begin
            // Latch is empty or draining here, so it is free when the product lands.
            state_q    <= MUL;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= opA;
            mplier_q   <= opB;
            irHold_q   <= IR_id;
            npcHold_q  <= NPC_id;
            bHold_q    <= B;
            outValid_q <= 1'b0;
          end else if (accept) begin
            outValid_q <= 1'b1;
            aluRes_q   <= aluResult;
            sel_q      <= takeBranch;
            npcEx_q    <= takeBranch ? aluResult : NPC_id;
            irEx_q     <= IR_id;
            bEx_q      <= B;
          end else if (outValid_q && out_ready) begin
            outValid_q <= 1'b0;
          end
        end
        MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + SHW'(1);
          if (cnt_q == SHW'(XLEN-1)) begin
            state_q    <= IDLE;
            outValid_q <= 1'b1;
            aluRes_q   <= acc_d;
            sel_q      <= 1'b0;
            npcEx_q    <= npcHold_q;
            irEx_q     <= irHold_q;
            bEx_q      <= bHold_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = outValid_q;
  assign NPC_ex    = npcEx_q;
  assign IR_ex     = irEx_q;
  assign ALU_res   = aluRes_q;
  assign B_ex      = bEx_q;
  assign sel       = sel_q;
  assign busy      = (state_q == MUL);

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Scoreboard bench: unsigned- and signed-compare instances share stimulus and
// are checked against a behavioural model; directed handshake/flush/reset checks.
module tb_exe_stage_pipe;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst, flush, inValid, outReady;
  logic [31:0] aIn, bIn, immIn, npcIn, irIn;

  logic        inReadyU, outValidU, selU, busyU;
  logic [31:0] npcExU, irExU, aluResU, bExU;
  logic        inReadyS, outValidS, selS, busyS;
  logic [31:0] npcExS, irExS, aluResS, bExS;

  typedef struct {
    logic [31:0] resU, resS, npc, ir, b;
    logic        sel;
  } expect_t;

  expect_t expQ[$];
  int nCompared = 0;
  int nMismatch = 0;

  exe_stage_pipe #(.XLEN(XLEN), .SIGNED_CMP(1'b0)) dutU (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReadyU),
    .A(aIn), .B(bIn), .Imm(immIn), .NPC_id(npcIn), .IR_id(irIn),
    .out_valid(outValidU), .out_ready(outReady), .NPC_ex(npcExU), .IR_ex(irExU),
    .ALU_res(aluResU), .B_ex(bExU), .sel(selU), .busy(busyU));

  exe_stage_pipe #(.XLEN(XLEN), .SIGNED_CMP(1'b1)) dutS (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_ready(inReadyS),
    .A(aIn), .B(bIn), .Imm(immIn), .NPC_id(npcIn), .IR_id(irIn),
    .out_valid(outValidS), .out_ready(outReady), .NPC_ex(npcExS), .IR_ex(irExS),
    .ALU_res(aluResS), .B_ex(bExS), .sel(selS), .busy(busyS));

  always #5 clk = ~clk;

  // Reference behaviour written straight from the instruction semantics.
  function automatic expect_t refModel(input logic [31:0] ir, a, bv, imm, npc);
    expect_t     e;
    logic [5:0]  op;
    logic [31:0] x, y;
    op = ir[31:26];
    x  = (op[5:2] == 4'b1101) ? npc : a;
    y  = op[4] ? imm : bv;
    if (op[5]) e.resU = x + y;
    else begin
      case (op[3:0])
        4'd0:    e.resU = x + y;
        4'd1:    e.resU = x - y;
        4'd2:    e.resU = x ^ y;
        4'd3:    e.resU = x & y;
        4'd4:    e.resU = x | y;
        4'd5:    e.resU = (x > y) ? 32'd1 : 32'd0;
        4'd6:    e.resU = x << y[4:0];
        4'd7:    e.resU = x >> y[4:0];
        4'd8:    e.resU = x * y;
        default: e.resU = 32'd0;
      endcase
    end
    e.resS = e.resU;
    if (!op[5] && op[3:0] == 4'd5) e.resS = ($signed(x) > $signed(y)) ? 32'd1 : 32'd0;
    e.sel = (op[5:1] == 5'b11010) && (op[0] != (a == 32'd0));
    e.npc = e.sel ? e.resU : npc;
    e.ir  = ir;
    e.b   = bv;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ir, a, bv, imm, npc,
                               input logic rdy, input logic fl, input logic rs, output logic acc);
    @(negedge clk);
    inValid = v; irIn = ir; aIn = a; bIn = bv; immIn = imm; npcIn = npc;
    outReady = rdy; flush = fl; rst = rs;
    #1;
    acc = v && inReadyU && !rs;
    if (acc) expQ.push_back(refModel(ir, a, bv, imm, npc));
    if (fl || rs) expQ.delete();
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    applyStimulus(1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, rdy, 1'b0, 1'b0, acc);
  endtask

  task automatic sendOp(input logic [31:0] ir, a, bv, imm, npc, input bit randReady);
    logic acc;
    int   waited;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 200) begin
      applyStimulus(1'b1, ir, a, bv, imm, npc,
                    randReady ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0, 1'b0, acc);
      waited++;
    end
    checkOutput("accept_in_time", acc, 1);
  endtask

  // Sends one op with the sink always ready and waits for its result in the latch.
  task automatic runDirected(input string name, input logic [31:0] ir, a, bv, imm, npc);
    int cyc;
    sendOp(ir, a, bv, imm, npc, 1'b0);
    cyc = 0;
    do begin
      idle(1'b1);
      cyc++;
    end while (!outValidU && cyc < 64);
    checkOutput({name, "_valid"}, outValidU, 1);
    if (ir[31:26] != 6'b001000) checkOutput({name, "_latency"}, cyc, 1);
  endtask

  // Monitor: pops the oldest expectation whenever the sink consumes a result.
  initial begin
    expect_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && !flush && outValidU && outReady) begin
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatch++;
          $display("[TB] FAIL unexpected_output: got result ir=%h, required no pending result", irExU);
        end else begin
          e = expQ.pop_front();
          checkOutput("sb_res_u", aluResU, e.resU);
          checkOutput("sb_res_s", aluResS, e.resS);
          checkOutput("sb_valid_s", outValidS, 1);
          checkOutput("sb_npc", npcExU, e.npc);
          checkOutput("sb_ir", irExU, e.ir);
          checkOutput("sb_b", bExU, e.b);
          checkOutput("sb_sel", selU, e.sel);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion, required $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        acc;
    logic [31:0] mulIr, secIr, xIr, yIr, x1, x2, y1, y2;
    logic [5:0]  op;
    expect_t     xExp, yExp;
    int          cyc;

    rst = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    aIn = '0; bIn = '0; immIn = '0; npcIn = '0; irIn = '0;

    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, acc);
    idle(1'b0);
    checkOutput("rst_out_valid", outValidU, 0);
    checkOutput("rst_busy", busyU, 0);
    checkOutput("rst_sel", selU, 0);
    checkOutput("rst_alu_res", aluResU, 0);
    checkOutput("rst_npc_ex", npcExU, 0);
    checkOutput("rst_ir_ex", irExU, 0);
    checkOutput("rst_b_ex", bExU, 0);
    checkOutput("rst_in_ready", inReadyU, 1);

    $display("[TB] directed ALU, compare, shift and branch ops");
    runDirected("add", 32'h0000_1234, 5, 7, 32'h55, 32'h400);
    checkOutput("add_res", aluResU, 32'd12);
    checkOutput("add_sel", selU, 0);
    checkOutput("add_npc", npcExU, 32'h400);
    runDirected("cmp", {6'b010101, 26'h0}, 3, 32'h99, 32'hFFFF_FFFF, 32'h404);
    checkOutput("cmp_unsigned", aluResU, 0);
    checkOutput("cmp_signed", aluResS, 1);
    runDirected("sll", {6'b010110, 26'h0}, 1, 32'h2, 32'd31, 32'h408);
    checkOutput("sll_res", aluResU, 32'h8000_0000);
    runDirected("beq_taken", {6'b110100, 26'h3}, 0, 32'h77, 32'd20, 32'd100);
    checkOutput("br_taken_sel", selU, 1);
    checkOutput("br_taken_npc", npcExU, 32'd120);
    runDirected("bne_not", {6'b110101, 26'h3}, 0, 32'h77, 32'd20, 32'd100);
    checkOutput("br_not_sel", selU, 0);
    checkOutput("br_not_npc", npcExU, 32'd100);

    $display("[TB] directed multiply with a second op held behind it");
    mulIr = {6'b001000, 26'h0};
    secIr = {6'b000000, 26'h1};
    sendOp(mulIr, 32'h0001_0003, 32'h0000_0005, 32'h0, 32'h500, 1'b0);
    for (int i = 1; i <= XLEN + 1; i++) begin
      applyStimulus(1'b1, secIr, 9, 1, 0, 32'h504, 1'b1, 1'b0, 1'b0, acc);
      if (i <= XLEN) begin
        checkOutput("mul_busy", busyU, 1);
        checkOutput("mul_in_ready", inReadyU, 0);
        checkOutput("mul_early_valid", outValidU, 0);
      end else begin
        checkOutput("mul_valid", outValidU, 1);
        checkOutput("mul_res", aluResU, 32'h0005_000F);
        checkOutput("mul_busy_done", busyU, 0);
        checkOutput("mul_second_accept", acc, 1);
      end
    end
    if (!acc) sendOp(secIr, 9, 1, 0, 32'h504, 1'b0);
    idle(1'b1);
    checkOutput("second_valid", outValidU, 1);
    checkOutput("second_res", aluResU, 32'd10);
    checkOutput("second_ir", irExU, secIr);

    $display("[TB] directed back-pressure");
    xIr = {6'b000010, 26'h2A}; x1 = $urandom; x2 = $urandom;
    yIr = {6'b000001, 26'h15}; y1 = $urandom; y2 = $urandom;
    xExp = refModel(xIr, x1, x2, 0, 32'h600);
    yExp = refModel(yIr, y1, y2, 0, 32'h604);
    sendOp(xIr, x1, x2, 0, 32'h600, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, yIr, y1, y2, 0, 32'h604, 1'b0, 1'b0, 1'b0, acc);
      checkOutput("bp_in_ready", inReadyU, 0);
      checkOutput("bp_valid", outValidU, 1);
      checkOutput("bp_res_hold", aluResU, xExp.resU);
      checkOutput("bp_ir_hold", irExU, xIr);
      checkOutput("bp_b_hold", bExU, x2);
    end
    applyStimulus(1'b1, yIr, y1, y2, 0, 32'h604, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("bp_drain_accept", acc, 1);
    idle(1'b0);
    checkOutput("bp_replaced_valid", outValidU, 1);
    checkOutput("bp_replaced_ir", irExU, yIr);
    checkOutput("bp_replaced_res", aluResU, yExp.resU);
    idle(1'b1);

    $display("[TB] directed flush during multiply");
    sendOp(mulIr, 32'h1234, 32'h77, 0, 32'h700, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b1);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0, acc);
    idle(1'b1);
    checkOutput("flush_busy", busyU, 0);
    checkOutput("flush_valid", outValidU, 0);
    checkOutput("flush_in_ready", inReadyU, 1);
    runDirected("post_flush_add", 32'h0000_0000, 20, 22, 0, 32'h704);
    checkOutput("post_flush_res", aluResU, 32'd42);

    $display("[TB] directed reset during multiply");
    sendOp(mulIr, 32'hABCD, 32'h3, 0, 32'h800, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    applyStimulus(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1, acc);
    idle(1'b1);
    checkOutput("mrst_busy", busyU, 0);
    checkOutput("mrst_valid", outValidU, 0);
    checkOutput("mrst_res", aluResU, 0);
    checkOutput("mrst_npc", npcExU, 0);
    checkOutput("mrst_ir", irExU, 0);
    checkOutput("mrst_b", bExU, 0);
    checkOutput("mrst_sel", selU, 0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 250; n++) begin
      cyc = $urandom_range(0, 9);
      if (cyc < 5)       op = {1'b0, 5'($urandom_range(0, 31))};
      else if (cyc == 5) op = {2'b00, 1'($urandom_range(0, 1)), 3'b000} | 6'b001000;
      else if (cyc < 8)  op = {5'b11010, 1'($urandom_range(0, 1))};
      else               op = {1'b1, 5'($urandom_range(0, 31))};
      x1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      sendOp({op, 26'($urandom)}, x1, $urandom, $urandom, $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
    end

    cyc = 0;
    while (expQ.size() > 0 && cyc < 200) begin
      idle(1'b1);
      cyc++;
    end
    idle(1'b1);
    checkOutput("drain_empty", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
